// File: rtl/imem_loader_pkg.sv
// Shared CPU-wide definitions for the instruction-memory loader and PC path.
package imem_loader_pkg;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned IDX_W           = 2;
    localparam int unsigned PC_STEP         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, memory-write and CPU-hold signals of the instruction loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic                 start;
    logic [CNT_W-1:0]     word_count;
    logic [BYTE_W-1:0]    byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 wr_en;
    logic [INSTR_W-1:0]   wr_addr;
    logic [INSTR_W-1:0]   wr_data;
    logic                 busy;
    logic                 done;
    logic                 cpu_hold;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
    );

endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes little-endian into a 32-bit instruction word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_done_c
);

    logic [IDX_W-1:0] idx;

    // The byte being accepted now completes the word.
    assign word_done_c = en && (idx == IDX_W'(BYTES_PER_INSTR - 1));

    // Byte index and word register; byte k lands in bits [8k+7:8k].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clr) begin
            idx  <= '0;
            word <= '0;
        end else if (en) begin
            word[{idx, 3'b000} +: BYTE_W] <= byte_in;
            idx                           <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory and holds the CPU until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    loader_state_t      state;
    loader_state_t      state_nxt;
    logic [CNT_W-1:0]   words_left;
    logic [INSTR_W-1:0] wr_addr_q;
    logic [INSTR_W-1:0] wr_data_w;
    logic               byte_ready_q;
    logic               wr_en_q;
    logic               busy_q;
    logic               done_q;
    logic               cpu_hold_q;
    logic               byte_ready_nxt;
    logic               wr_en_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               cpu_hold_nxt;
    logic               start_ok;
    logic               accept;
    logic               word_done;

    assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept   = bus.byte_valid && byte_ready_q;

    imem_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start_ok),
        .en          (accept),
        .byte_in     (bus.byte_in),
        .word        (wr_data_w),
        .word_done_c (word_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured when not busy.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt = (bus.word_count != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (word_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = (words_left == CNT_W'(1)) ? ST_DONE : ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        byte_ready_nxt = 1'b0;
        wr_en_nxt      = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        cpu_hold_nxt   = 1'b1;
        case (state_nxt)
            ST_LOAD: begin
                byte_ready_nxt = 1'b1;
                busy_nxt       = 1'b1;
            end
            ST_WRITE: begin
                wr_en_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            ST_DONE: begin
                done_nxt     = 1'b1;
                cpu_hold_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            byte_ready_q <= byte_ready_nxt;
            wr_en_q      <= wr_en_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            cpu_hold_q   <= cpu_hold_nxt;
        end
    end

    // Write address and remaining-word counter; both advance as WRITE is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= BASE_ADDR;
            words_left <= '0;
        end else if (start_ok) begin
            wr_addr_q  <= BASE_ADDR;
            words_left <= CNT_W'(bus.word_count);
        end else if (state == ST_WRITE) begin
            wr_addr_q  <= wr_addr_q + INSTR_W'(PC_STEP);
            words_left <= words_left - CNT_W'(1);
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_w;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus reset/corner sequences.
module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if #(.CNT_W(16)) bus ();

    imem_loader #(.BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_rec_t;

    typedef struct {
        int unsigned wc;
        bit          gapped;
        int          poke_at;      // byte index at which a stray start is pulsed, -1 = none
        logic [7:0]  bytes [12];
        logic [31:0] exp_data [3];
        int unsigned exp_cycles;   // first LOAD cycle to DONE entry, 0 = not checked
    } vec_t;

    wr_rec_t writes_q [$];
    int      checks;
    int      errors;
    int      rdy_in_write;
    int      wr_en_double;
    bit      prev_wr_en;
    vec_t    vecs [6];

    // Log every memory write, and flag overlong strobes or ready during a write.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            writes_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            if (bus.byte_ready) rdy_in_write++;
            if (prev_wr_en) wr_en_double++;
        end
        prev_wr_en = bus.wr_en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; returns at 1ns after that edge.
    task automatic do_start(input logic [15:0] wc);
        bus.start      = 1'b1;
        bus.word_count = wc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int  idx;
        int  cycles;
        bit  poked;
        bit  accepted;
        writes_q.delete();
        do_start(16'(v.wc));
        check($sformatf("v%0d_ready_after_start", n), 32'(bus.byte_ready), 32'd1);
        idx    = 0;
        cycles = 0;
        poked  = 1'b0;
        while (!bus.done && cycles < 300) begin
            if (v.poke_at >= 0 && idx == v.poke_at && !poked) begin
                bus.start      = 1'b1;
                bus.word_count = 16'd5;
                poked          = 1'b1;
            end
            if (idx < int'(4 * v.wc) && (!v.gapped || $urandom_range(0, 2) != 0)) begin
                bus.byte_valid = 1'b1;
                bus.byte_in    = v.bytes[idx];
            end else begin
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'hEE;
            end
            accepted = bus.byte_valid && bus.byte_ready;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (accepted) idx++;
            cycles++;
        end
        bus.byte_valid = 1'b0;
        check($sformatf("v%0d_done", n), 32'(bus.done), 32'd1);
        check($sformatf("v%0d_bytes_used", n), 32'(idx), 32'(4 * v.wc));
        if (v.exp_cycles != 0)
            check($sformatf("v%0d_cycles", n), 32'(cycles), 32'(v.exp_cycles));
        check($sformatf("v%0d_nwrites", n), 32'(writes_q.size()), 32'(v.wc));
        for (int i = 0; i < int'(v.wc) && i < writes_q.size(); i++) begin
            check($sformatf("v%0d_addr%0d", n, i), writes_q[i].addr, 32'(4 * i));
            check($sformatf("v%0d_data%0d", n, i), writes_q[i].data, v.exp_data[i]);
        end
        check($sformatf("v%0d_cpu_hold", n), 32'(bus.cpu_hold), 32'd0);
        check($sformatf("v%0d_busy", n), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        bit accepted;

        checks         = 0;
        errors         = 0;
        rdy_in_write   = 0;
        wr_en_double   = 0;
        prev_wr_en     = 1'b0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        vecs[0] = '{wc: 1, gapped: 0, poke_at: -1,
                    bytes: '{8'h20, 8'h00, 8'h80, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00},
                    exp_data: '{32'hD280_0020, 32'h0, 32'h0}, exp_cycles: 5};
        vecs[1] = '{wc: 3, gapped: 0, poke_at: -1,
                    bytes: '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                             8'h33, 8'h86, 8'hB5, 8'h00},
                    exp_data: '{32'h0010_0513, 32'h0020_0593, 32'h00B5_8633}, exp_cycles: 15};
        vecs[2] = '{wc: 3, gapped: 1, poke_at: -1,
                    bytes: '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                             8'h33, 8'h86, 8'hB5, 8'h00},
                    exp_data: '{32'h0010_0513, 32'h0020_0593, 32'h00B5_8633}, exp_cycles: 0};
        vecs[3] = '{wc: 2, gapped: 1, poke_at: -1,
                    bytes: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h00, 8'h00, 8'h00, 8'h00},
                    exp_data: '{32'h0403_0201, 32'h0807_0605, 32'h0}, exp_cycles: 0};
        vecs[4] = '{wc: 2, gapped: 0, poke_at: 2,
                    bytes: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h00, 8'h00, 8'h00, 8'h00},
                    exp_data: '{32'h0403_0201, 32'h0807_0605, 32'h0}, exp_cycles: 10};
        vecs[5] = '{wc: 1, gapped: 0, poke_at: -1,
                    bytes: '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00},
                    exp_data: '{32'hAABB_CCDD, 32'h0, 32'h0}, exp_cycles: 5};

        // Values held in reset.
        #12;
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", bus.wr_addr, 32'h0);
        check("rst_wr_data", bus.wr_data, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("idle_done", 32'(bus.done), 32'd0);

        // Zero-word load completes one cycle after start, without writing.
        writes_q.delete();
        do_start(16'd0);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        check("zero_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("zero_nwrites", 32'(writes_q.size()), 32'd0);

        for (int n = 0; n < 5; n++) begin
            run_vec(n, vecs[n]);
        end
        check("ready_during_write", 32'(rdy_in_write), 32'd0);
        check("wr_en_single_cycle", 32'(wr_en_double), 32'd0);

        // DONE refuses bytes.
        writes_q.delete();
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        check("done_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("done_no_write", 32'(writes_q.size()), 32'd0);
        check("done_still_done", 32'(bus.done), 32'd1);

        // Reset after six of eight bytes, then reload a single word.
        writes_q.delete();
        do_start(16'd2);
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 50) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = 8'h10 + 8'(idx);
            accepted = bus.byte_ready;
            @(posedge clk);
            #1;
            if (accepted) idx++;
            cyc++;
        end
        bus.byte_valid = 1'b0;
        check("mid_bytes_fed", 32'(idx), 32'd6);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_wr_addr", bus.wr_addr, 32'h0);
        check("mid_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("mid_first_word_written", 32'(writes_q.size()), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(5, vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
